// File: rtl/vga_mono_filter.sv
// Three-stage video post-processor: Rec.709 luma, mono/amber/inverse modes, scanline dimming,
// blanking, and mode/scanline latching only at the vsync active edge so a frame never mixes modes.
module vga_mono_filter #(
  parameter int CW       = 6,
  parameter int OW       = 6,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          de_in,
  input  logic [2:0]    mode_req,
  input  logic          scanline_req,
  output logic [OW-1:0] r_out,
  output logic [OW-1:0] g_out,
  output logic [OW-1:0] b_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out,
  output logic [2:0]    mode_active,
  output logic          line_odd
);

  typedef enum logic [2:0] {
    M_COLOUR = 3'd0,
    M_GREEN  = 3'd1,
    M_AMBER  = 3'd2,
    M_WHITE  = 3'd3,
    M_INV    = 3'd4
  } mode_t;

  localparam logic ACT   = SYNC_POL;
  localparam logic INACT = ~SYNC_POL;
  localparam logic [CW+7:0] K_R = (CW+8)'(54);
  localparam logic [CW+7:0] K_G = (CW+8)'(183);
  localparam logic [CW+7:0] K_B = (CW+8)'(19);

  logic    r_vs_prev, r_hs_prev, r_scan_en, r_odd;
  mode_t   r_mode, w_mode_map;
  logic    w_vs_edge, w_hs_edge;

  logic [CW-1:0] r_s1_r, r_s1_g, r_s1_b;
  logic [CW+7:0] r_s1_pr, r_s1_pg, r_s1_pb;
  mode_t         r_s1_mode;
  logic          r_s1_dim, r_s1_hs, r_s1_vs, r_s1_de;

  logic [CW+8:0] w_sum;
  logic [CW-1:0] w_y, w_c2_r, w_c2_g, w_c2_b;
  logic [CW-1:0] r_s2_r, r_s2_g, r_s2_b;
  logic          r_s2_dim, r_s2_hs, r_s2_vs, r_s2_de;

  logic [CW-1:0] w_d_r, w_d_g, w_d_b;
  logic [OW-1:0] r_r_out, r_g_out, r_b_out;
  logic          r_hs_out, r_vs_out, r_de_out;

  assign w_vs_edge = (vsync_in == ACT) && (r_vs_prev == INACT);
  assign w_hs_edge = (hsync_in == ACT) && (r_hs_prev == INACT);

  always_comb begin
    w_mode_map = M_COLOUR;
    case (mode_req)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: w_mode_map = mode_t'(mode_req);
      default:                      w_mode_map = M_COLOUR;
    endcase
  end

  // Vsync clear takes priority over the hsync toggle in the same cycle.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_vs_prev <= INACT;
      r_hs_prev <= INACT;
      r_mode    <= M_COLOUR;
      r_scan_en <= 1'b0;
      r_odd     <= 1'b0;
    end else begin
      r_vs_prev <= vsync_in;
      r_hs_prev <= hsync_in;
      if (w_vs_edge) begin
        r_mode    <= w_mode_map;
        r_scan_en <= scanline_req;
        r_odd     <= 1'b0;
      end else if (w_hs_edge) begin
        r_odd <= ~r_odd;
      end
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_s1_r <= {CW{1'b0}}; r_s1_g <= {CW{1'b0}}; r_s1_b <= {CW{1'b0}};
      r_s1_pr <= {(CW+8){1'b0}}; r_s1_pg <= {(CW+8){1'b0}}; r_s1_pb <= {(CW+8){1'b0}};
      r_s1_mode <= M_COLOUR;
      r_s1_dim  <= 1'b0;
      r_s1_hs   <= INACT;
      r_s1_vs   <= INACT;
      r_s1_de   <= 1'b0;
    end else begin
      r_s1_r    <= r_in;
      r_s1_g    <= g_in;
      r_s1_b    <= b_in;
      r_s1_pr   <= {8'd0, r_in} * K_R;
      r_s1_pg   <= {8'd0, g_in} * K_G;
      r_s1_pb   <= {8'd0, b_in} * K_B;
      r_s1_mode <= r_mode;
      r_s1_dim  <= r_scan_en & r_odd;
      r_s1_hs   <= hsync_in;
      r_s1_vs   <= vsync_in;
      r_s1_de   <= de_in;
    end
  end

  // Weights sum to 256, so the top bit of the sum is always clear and Y fits in CW bits.
  assign w_sum = {1'b0, r_s1_pr} + {1'b0, r_s1_pg} + {1'b0, r_s1_pb};
  assign w_y   = w_sum[CW+7:8];

  always_comb begin
    w_c2_r = r_s1_r;
    w_c2_g = r_s1_g;
    w_c2_b = r_s1_b;
    case (r_s1_mode)
      M_COLOUR: begin w_c2_r = r_s1_r;      w_c2_g = r_s1_g;      w_c2_b = r_s1_b;      end
      M_GREEN:  begin w_c2_r = {CW{1'b0}};  w_c2_g = w_y;         w_c2_b = {CW{1'b0}};  end
      M_AMBER:  begin w_c2_r = w_y;         w_c2_g = w_y >> 1;    w_c2_b = {CW{1'b0}};  end
      M_WHITE:  begin w_c2_r = w_y;         w_c2_g = w_y;         w_c2_b = w_y;         end
      M_INV:    begin w_c2_r = ~w_y;        w_c2_g = ~w_y;        w_c2_b = ~w_y;        end
      default:  begin w_c2_r = r_s1_r;      w_c2_g = r_s1_g;      w_c2_b = r_s1_b;      end
    endcase
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_s2_r <= {CW{1'b0}}; r_s2_g <= {CW{1'b0}}; r_s2_b <= {CW{1'b0}};
      r_s2_dim <= 1'b0;
      r_s2_hs  <= INACT;
      r_s2_vs  <= INACT;
      r_s2_de  <= 1'b0;
    end else begin
      r_s2_r   <= w_c2_r;
      r_s2_g   <= w_c2_g;
      r_s2_b   <= w_c2_b;
      r_s2_dim <= r_s1_dim;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
      r_s2_de  <= r_s1_de;
    end
  end

  assign w_d_r = r_s2_dim ? (r_s2_r >> 1) : r_s2_r;
  assign w_d_g = r_s2_dim ? (r_s2_g >> 1) : r_s2_g;
  assign w_d_b = r_s2_dim ? (r_s2_b >> 1) : r_s2_b;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_r_out <= {OW{1'b0}}; r_g_out <= {OW{1'b0}}; r_b_out <= {OW{1'b0}};
      r_hs_out <= INACT;
      r_vs_out <= INACT;
      r_de_out <= 1'b0;
    end else begin
      r_r_out  <= r_s2_de ? w_d_r[CW-1 -: OW] : {OW{1'b0}};
      r_g_out  <= r_s2_de ? w_d_g[CW-1 -: OW] : {OW{1'b0}};
      r_b_out  <= r_s2_de ? w_d_b[CW-1 -: OW] : {OW{1'b0}};
      r_hs_out <= r_s2_hs;
      r_vs_out <= r_s2_vs;
      r_de_out <= r_s2_de;
    end
  end

  assign r_out       = r_r_out;
  assign g_out       = r_g_out;
  assign b_out       = r_b_out;
  assign hsync_out   = r_hs_out;
  assign vsync_out   = r_vs_out;
  assign de_out      = r_de_out;
  assign mode_active = r_mode;
  assign line_odd    = r_odd;

endmodule
